// File: rtl/seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_if
// Request/response bundle between the execute stage and the iterative
// multiplier.
//   start     : request strobe, honoured only while busy is low
//   is_signed : 1 = two's-complement operands, 0 = unsigned
//   flush     : abort whatever operation is in flight
//   a, b      : multiplicand / multiplier (WIDTH bits)
//   busy      : operation in progress, requester must hold
//   done      : one-cycle completion pulse
//   product   : 2*WIDTH-bit result, held until the next done
// The master modport belongs to the requester, the slave modport to the
// multiplier.
// -----------------------------------------------------------------------------
interface seq_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic                 start;
    logic                 is_signed;
    logic                 flush;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, flush, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, flush, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, one multiplier bit per clock. Signed
// operands are converted to magnitudes on accept and the sign is restored in a
// final FIX cycle, so latency is always WIDTH+1 cycles from accept to done.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : seq_multiplier_if slave modport (start/is_signed/flush/a/b in,
//         busy/done/product out, all outputs registered)
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_reg,   state_next;
    logic [WIDTH-1:0]     mcand_reg,   mcand_next;
    logic [WIDTH-1:0]     mplier_reg,  mplier_next;
    logic [2*WIDTH-1:0]   acc_reg,     acc_next;
    logic [CNT_W-1:0]     cnt_reg,     cnt_next;
    logic                 neg_reg,     neg_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;
    logic                 done_reg,    done_next;
    logic                 busy_reg,    busy_next;

    // Operand magnitudes. Negating the most negative value wraps back to
    // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Upper half plus optional multiplicand, with one carry bit that is
    // shifted back into the accumulator MSB.
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   acc_shifted;

    always_comb begin
        a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        if (mplier_reg[0]) begin
            add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
        end else begin
            add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
        end
        acc_shifted = {add_sum, acc_reg[WIDTH-1:1]};
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        neg_next     = neg_reg;
        product_next = product_reg;
        done_next    = 1'b0;

        if (bus.flush) begin
            // Abort wins over everything, including a start in the same cycle.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // IDLE also covers the done cycle, giving back-to-back
                    // acceptance without a dead cycle.
                    if (bus.start) begin
                        mcand_next  = a_mag;
                        mplier_next = b_mag;
                        neg_next    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_next    = '0;
                        cnt_next    = '0;
                        state_next  = RUN;
                    end
                end
                RUN: begin
                    acc_next    = acc_shifted;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    product_next = neg_reg ? -acc_reg : acc_reg;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            product_reg <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            neg_reg     <= neg_next;
            product_reg <= product_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Directed vectors and handshake/flush/reset sequences on a WIDTH=32 instance,
// random back-to-back regression on a WIDTH=8 instance. Expected products are
// queued when a request is driven and popped by a monitor on each done pulse,
// which also checks the accept-to-done latency.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] prod;
        int          accept;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] prod;
    } vec_t;

    logic clk;
    logic rst32;
    logic rst8;
    int   cyc;
    int   checks;
    int   errors;

    exp_t q32[$];
    exp_t q8[$];

    seq_multiplier_if #(.WIDTH(32)) bus32 ();
    seq_multiplier_if #(.WIDTH(8))  bus8 ();

    seq_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(bus32));
    seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus32.done === 1'b1) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL done32_unexpected: got done with product 0x%0h, expected none", bus32.product);
            end else begin
                e = q32.pop_front();
                $display("done32 cycle=%0d product=0x%016h expected=0x%016h", cyc, bus32.product, e.prod);
                if (bus32.product !== e.prod) begin
                    errors++;
                    $display("FAIL product32: got 0x%0h, expected 0x%0h", bus32.product, e.prod);
                end
                checks++;
                if (cyc != e.accept + 33) begin
                    errors++;
                    $display("FAIL latency32: got %0d, expected 33", cyc - e.accept);
                end
            end
        end
        if (bus8.done === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected: got done with product 0x%0h, expected none", bus8.product);
            end else begin
                e = q8.pop_front();
                $display("done8 cycle=%0d product=0x%04h expected=0x%04h", cyc, bus8.product, e.prod[15:0]);
                if ({48'd0, bus8.product} !== e.prod) begin
                    errors++;
                    $display("FAIL product8: got 0x%0h, expected 0x%0h", bus8.product, e.prod);
                end
                checks++;
                if (cyc != e.accept + 9) begin
                    errors++;
                    $display("FAIL latency8: got %0d, expected 9", cyc - e.accept);
                end
            end
        end
    end

    function automatic logic [63:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [15:0]        p;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            p  = sa * sb;
        end else begin
            p = {8'd0, a} * {8'd0, b};
        end
        return {48'd0, p};
    endfunction

    // Drive one start cycle; the request is accepted at the next edge.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] prod, input bit push);
        exp_t e;
        bus32.a         = a;
        bus32.b         = b;
        bus32.is_signed = s;
        bus32.start     = 1'b1;
        if (push) begin
            e.prod   = prod;
            e.accept = cyc + 1;
            q32.push_back(e);
        end
        tick();
        bus32.start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        bus8.a         = a;
        bus8.b         = b;
        bus8.is_signed = s;
        bus8.start     = 1'b1;
        e.prod   = model8(a, b, s);
        e.accept = cyc + 1;
        q8.push_back(e);
        tick();
        bus8.start = 1'b0;
    endtask

    task automatic wait_done32(input int limit);
        int n;
        n = 0;
        while (q32.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (q32.size() != 0) begin
            errors++;
            $display("FAIL timeout32: got %0d pending, expected 0", q32.size());
            q32.delete();
        end
    endtask

    task automatic wait_done8(input int limit);
        int n;
        n = 0;
        while (q8.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL timeout8: got %0d pending, expected 0", q8.size());
            q8.delete();
        end
    endtask

    // Watch a window of cycles for any done pulse on the 32-bit instance.
    task automatic no_done32(input string name, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (bus32.done === 1'b1) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [63:0] prod_before;
        logic        ok8;
        int          waited;

        checks = 0;
        errors = 0;

        vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[2]  = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[3]  = '{32'h0000_0006, 32'h0000_0007, 1'b0, 64'h0000_0000_0000_002A};
        vecs[4]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
        vecs[8]  = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[11] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE};

        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.flush = 1'b0;
        bus32.a = '0; bus32.b = '0;
        bus8.start = 1'b0; bus8.is_signed = 1'b0; bus8.flush = 1'b0;
        bus8.a = '0; bus8.b = '0;
        rst32 = 1'b0;
        rst8  = 1'b0;

        repeat (3) tick();
        rst32 = 1'b1;
        rst8  = 1'b1;
        tick();
        chk("reset_busy32",    {63'd0, bus32.busy}, 64'd0);
        chk("reset_done32",    {63'd0, bus32.done}, 64'd0);
        chk("reset_product32", bus32.product, 64'd0);
        chk("reset_busy8",     {63'd0, bus8.busy}, 64'd0);
        chk("reset_product8",  {48'd0, bus8.product}, 64'd0);

        // Directed table, one operation at a time.
        for (int i = 0; i < 12; i++) begin
            issue32(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].prod, 1'b1);
            chk("busy_after_accept", {63'd0, bus32.busy}, 64'd1);
            wait_done32(40);
        end

        // A second start 5 cycles into an operation is ignored.
        issue32(32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340, 1'b1);
        repeat (4) tick();
        issue32(32'h0000_0063, 32'h0000_0063, 1'b0, 64'd0, 1'b0);
        wait_done32(40);
        no_done32("ignored_start_no_done", 40);

        // Start held high through the done cycle is accepted right there.
        issue32(32'h0000_0003, 32'h0000_0004, 1'b0, 64'd12, 1'b1);
        bus32.a     = 32'd6;
        bus32.b     = 32'd7;
        bus32.start = 1'b1;
        waited = 0;
        while (bus32.done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("held_start_done_seen", {63'd0, bus32.done}, 64'd1);
        q32.push_back('{64'd42, cyc + 1});
        tick();
        bus32.start = 1'b0;
        wait_done32(40);
        chk("held_start_product", bus32.product, 64'd42);

        // Flush on the 10th RUN cycle.
        prod_before = bus32.product;
        issue32(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);
        repeat (9) tick();
        bus32.flush = 1'b1;
        tick();
        bus32.flush = 1'b0;
        chk("flush_busy",    {63'd0, bus32.busy}, 64'd0);
        chk("flush_done",    {63'd0, bus32.done}, 64'd0);
        chk("flush_product", bus32.product, prod_before);
        no_done32("flush_no_done", 40);

        // Flush together with start in IDLE starts nothing.
        bus32.a = 32'd9; bus32.b = 32'd9;
        bus32.start = 1'b1;
        bus32.flush = 1'b1;
        tick();
        bus32.start = 1'b0;
        bus32.flush = 1'b0;
        chk("flush_start_busy", {63'd0, bus32.busy}, 64'd0);
        no_done32("flush_start_no_done", 40);
        chk("flush_start_product", bus32.product, prod_before);

        // Asynchronous reset between edges during RUN.
        issue32(32'h0000_0055, 32'h0000_0003, 1'b0, 64'd0, 1'b0);
        repeat (5) tick();
        #2;
        rst32 = 1'b0;
        #1;
        chk("async_reset_busy",    {63'd0, bus32.busy}, 64'd0);
        chk("async_reset_done",    {63'd0, bus32.done}, 64'd0);
        chk("async_reset_product", bus32.product, 64'd0);
        tick();
        rst32 = 1'b1;
        tick();
        issue32(32'd2, 32'd0, 1'b0, 64'd0, 1'b1);
        wait_done32(40);
        chk("post_reset_product", bus32.product, 64'd0);

        // Random back-to-back regression on the 8-bit instance.
        ok8 = 1'b1;
        issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        for (int n = 1; n < 2000 && ok8; n++) begin
            waited = 0;
            while (bus8.done !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            if (bus8.done !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL random8_timeout: got no done after %0d cycles, expected 9", waited);
                ok8 = 1'b0;
            end else begin
                issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end
        wait_done8(20);

        tick();
        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q8_empty",  64'(q8.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative shift-add multiplier. It replaces the single-cycle multiplier in the execute stage. It accepts a multiply request through a start/busy/done handshake and produces the full double-width product after a fixed latency. It supports signed and unsigned operands and a pipeline flush. The execute stage holds the pipeline on `busy`.

## Interface
- `WIDTH`, default 32: operand width in bits; must be ≥ 4. Product width is 2*WIDTH.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; sampled only when `busy`=0.
- `is_signed` input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `flush` input, 1 bit: synchronous abort of any operation in progress.
- `a` input, WIDTH bits: multiplicand; sampled with `start`.
- `b` input, WIDTH bits: multiplier; sampled with `start`.
- `busy` output, 1 bit: operation in progress; new requests are ignored while high.
- `done` output, 1 bit: one-cycle pulse; `product` is valid from this cycle on.
- `product` output, 2*WIDTH bits: registered result; holds until the next `done`.

## Operation
- States are IDLE, RUN and FIX. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `product`=0. Internal accumulator, counter and operand registers are all 0.
- **IDLE, or the FIX→IDLE `done` cycle, with `start`=1 and `flush`=0:**
  - Capture |a| and |b| as WIDTH-bit unsigned magnitudes. Negation applies only when `is_signed`=1 and the operand MSB is 1.
  - Record `neg` = `is_signed` & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator, set the counter to 0, and go to RUN.
- **RUN:** one iteration per cycle.
  - If the current multiplier LSB is 1, add the multiplicand to the upper half of the accumulator, keeping the carry.
  - Shift the accumulator right by 1 and the multiplier right by 1.
  - Increment the counter.
  - After the WIDTH-th iteration, go to FIX.
- **FIX:**
  - `product` ← `neg` ? −accumulator (2*WIDTH two's complement) : accumulator.
  - Pulse `done` and go to IDLE.
- `busy` = 1 in RUN and FIX, 0 otherwise.
- Arithmetic rules:
  - Magnitudes are WIDTH-bit unsigned, so −2^(WIDTH−1) has magnitude 2^(WIDTH−1) and is exact.
  - The unsigned result is exact in 2*WIDTH bits.
  - The signed result is exact in 2*WIDTH bits for all operand pairs, including (−2^(WIDTH−1))², which gives 2^(2*WIDTH−2).
- **Flush:**
  - `flush`=1 in any state sends the block to IDLE at the next edge.
  - No `done` pulse is produced and `product` is unchanged.
  - Flush has priority over `start` in the same cycle; that request is dropped.
- `start` while `busy`=1 is ignored and has no side effects. Requests are not queued.
- **Reset mid-operation:** the block returns immediately to its reset values. The aborted result is lost.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0.
- Edges E1..E_WIDTH perform the WIDTH iterations.
- Edge E_{WIDTH+1} performs the FIX step, so `done`=1, `busy`=0 and `product` is valid for the cycle after E_{WIDTH+1}.
- Latency is fixed at WIDTH+1 cycles from accept to `done` and is independent of operand values, including zero.
- Throughput: a `start` held high during the `done` cycle is accepted at that edge. Back-to-back operations therefore occupy WIDTH+2 cycles each.
- `done` is high for exactly one cycle per completed operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Unsigned, WIDTH=32:** a=0xFFFFFFFF, b=0xFFFFFFFF, `is_signed`=0 → `done` 33 cycles after the accept edge; `product`=0xFFFFFFFE00000001.
- **Signed corner, WIDTH=32:** a=0x80000000, b=0x80000000, `is_signed`=1 → `product`=0x4000000000000000. Then a=0xFFFFFFFD (−3), b=7 → `product`=0xFFFFFFFFFFFFFFEB (−21).
- **Handshake:** pulse `start` again 5 cycles after accept with different operands → the second request is ignored and the first result is correct. Hold `start` through the `done` cycle with a=6, b=7 → the next `done` comes 34 cycles later with `product`=42.
- **Flush:** accept a=3, b=5, then assert `flush` on the 10th RUN cycle → `busy`=0 next cycle, no `done`, `product` keeps its prior value. `flush`+`start` in IDLE → no operation starts.
- **Reset mid-operation:** deassert `rst` asynchronously between clock edges during RUN → `busy`, `done` and `product` are 0 immediately. After release, a=2, b=0 → `product`=0 after WIDTH+1 cycles.
- **Random regression, WIDTH=8:** 2000 random operand pairs with random `is_signed`, compared against a reference model → all 16-bit products match and latency is exactly 9 cycles.
